video_dot_serializer: RTL and testbench

- Final pixel stage of the video path; sits directly downstream of the character fetch/char-ROM stage exercised by the video bench.
- Buffers fetched character-cell rows in a small FIFO and shifts them out MSB-first, one dot per dot strobe.
- Applies reverse and blank attributes.
- Re-times h/v sync to the same dot edge as pixels so the monitor interface sees aligned video.

---
 rtl/video_pkg.sv | 13 +
 rtl/video_cell_fifo.sv | 61 ++++++
 rtl/video_dot_serializer.sv | 109 ++++++++++
 tb/tb_video_dot_serializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types for the video output path: the character-cell record that travels
// from the char-ROM fetch stage into the dot serializer.
package video_pkg;

    localparam int DEFAULT_DOTS_PER_CHAR = 8;

    typedef struct packed {
        logic [DEFAULT_DOTS_PER_CHAR-1:0] pixels;
        logic                             reverse;
        logic                             blank;
    } cell_t;

endpackage

// File: rtl/video_cell_fifo.sv
// Small register-based synchronous FIFO of character cells. Push is accepted on
// valid & ~full; pop is a strobe that is ignored while empty.
module video_cell_fifo
    import video_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic  clk_i,
    input  logic  reset_i,
    input  logic  push_valid_i,
    input  cell_t push_data_i,
    input  logic  pop_i,
    output cell_t pop_data_o,
    output logic  empty_o,
    output logic  full_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    cell_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign full_o     = (count == CNT_W'(FIFO_DEPTH));
    assign empty_o    = (count == '0);
    assign push       = push_valid_i & ~full_o;
    assign pop        = pop_i & ~empty_o;
    assign pop_data_o = mem[rd_ptr];

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/video_dot_serializer.sv
// Final pixel stage: queues character-cell rows and shifts them out MSB-first,
// one dot per dot strobe, with attributes applied and syncs aligned to the dots.
module video_dot_serializer
    import video_pkg::*;
#(
    parameter int DOTS_PER_CHAR = DEFAULT_DOTS_PER_CHAR,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     dot_en_i,
    input  logic                     cell_valid_i,
    output logic                     cell_ready_o,
    input  logic [DOTS_PER_CHAR-1:0] pixels_i,
    input  logic                     reverse_i,
    input  logic                     blank_i,
    input  logic                     h_sync_i,
    input  logic                     v_sync_i,
    output logic                     video_o,
    output logic                     h_sync_o,
    output logic                     v_sync_o,
    output logic                     underrun_o
);

    localparam int CNT_W = (DOTS_PER_CHAR > 1) ? $clog2(DOTS_PER_CHAR) : 1;
    localparam int MSB   = DOTS_PER_CHAR - 1;

    cell_t            push_cell;
    cell_t            head_cell;
    logic             fifo_empty;
    logic             fifo_full;
    logic             load;

    logic [CNT_W-1:0] dot_cnt;
    logic [MSB:0]     shift_p0;
    logic             rev_p0;
    logic             blank_p0;
    logic [MSB:0]     shift_d;
    logic             rev_d;
    logic             blank_d;
    logic             video_d;

    assign push_cell    = '{pixels: pixels_i, reverse: reverse_i, blank: blank_i};
    assign cell_ready_o = ~fifo_full;
    assign load         = dot_en_i && (dot_cnt == '0);

    // The pop strobe is the load edge; on an empty FIFO it is a no-op and the
    // load underruns, so a same-cycle push never falls through.
    video_cell_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_cell_fifo (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_valid_i (cell_valid_i),
        .push_data_i  (push_cell),
        .pop_i        (load),
        .pop_data_o   (head_cell),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full)
    );

    // Next shifter contents; the output dot is always the MSB of what gets
    // registered, so the first dot of a cell leaves on its load edge.
    always_comb begin
        shift_d = shift_p0;
        rev_d   = rev_p0;
        blank_d = blank_p0;
        if (load) begin
            if (!fifo_empty) begin
                shift_d = head_cell.pixels;
                rev_d   = head_cell.reverse;
                blank_d = head_cell.blank;
            end else begin
                shift_d = '0;
                rev_d   = 1'b0;
                blank_d = 1'b1;
            end
        end else if (dot_en_i) begin
            shift_d = shift_p0 << 1;
        end
        video_d = (shift_d[MSB] ^ rev_d) & ~blank_d;
    end

    // Dot-edge register stage: pixel and syncs share one edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dot_cnt    <= '0;
            shift_p0   <= '0;
            rev_p0     <= 1'b0;
            blank_p0   <= 1'b1;
            video_o    <= 1'b0;
            h_sync_o   <= 1'b0;
            v_sync_o   <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= load & fifo_empty;
            if (dot_en_i) begin
                dot_cnt  <= (dot_cnt == CNT_W'(MSB)) ? '0 : dot_cnt + CNT_W'(1);
                shift_p0 <= shift_d;
                rev_p0   <= rev_d;
                blank_p0 <= blank_d;
                video_o  <= video_d;
                h_sync_o <= h_sync_i;
                v_sync_o <= v_sync_i;
            end
        end
    end

endmodule

// File: tb/tb_video_dot_serializer.sv
// Bench for video_dot_serializer: directed scenarios plus random traffic, checked
// against a queue-based model of cells and dot positions.
module tb_video_dot_serializer;

    localparam int DOTS  = 8;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            reset_i;
    logic            dot_en_i;
    logic            cell_valid_i;
    logic            cell_ready_o;
    logic [DOTS-1:0] pixels_i;
    logic            reverse_i;
    logic            blank_i;
    logic            h_sync_i;
    logic            v_sync_i;
    logic            video_o;
    logic            h_sync_o;
    logic            v_sync_o;
    logic            underrun_o;

    video_dot_serializer #(
        .DOTS_PER_CHAR (DOTS),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .dot_en_i     (dot_en_i),
        .cell_valid_i (cell_valid_i),
        .cell_ready_o (cell_ready_o),
        .pixels_i     (pixels_i),
        .reverse_i    (reverse_i),
        .blank_i      (blank_i),
        .h_sync_i     (h_sync_i),
        .v_sync_i     (v_sync_i),
        .video_o      (video_o),
        .h_sync_o     (h_sync_o),
        .v_sync_o     (v_sync_o),
        .underrun_o   (underrun_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DOTS-1:0] pix;
        bit              rv;
        bit              bl;
    } mcell_t;

    int        n_assert = 0;
    int        n_fail   = 0;

    mcell_t    q[$];
    mcell_t    cur;
    int        phase;
    bit        m_video, m_hs, m_vs, m_urun, m_acc;
    logic [7:0] seen;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        phase   = 0;
        cur     = '{pix: '0, rv: 1'b0, bl: 1'b1};
        m_video = 0; m_hs = 0; m_vs = 0; m_urun = 0; m_acc = 0;
    endtask

    // One clock: drive at negedge, check ready, advance model, check outputs after posedge.
    task automatic cyc(input bit en, input bit vld, input logic [7:0] pix,
                       input bit rv, input bit bl, input bit hs, input bit vs);
        bit exp_ready;
        @(negedge clk);
        dot_en_i     = en;
        cell_valid_i = vld;
        pixels_i     = pix;
        reverse_i    = rv;
        blank_i      = bl;
        h_sync_i     = hs;
        v_sync_i     = vs;
        #1;
        exp_ready = (q.size() < DEPTH);
        chk("cell_ready", cell_ready_o, exp_ready);
        m_acc = vld && exp_ready;
        if (en) begin
            if (phase == 0) begin
                if (q.size() > 0) begin
                    cur    = q.pop_front();
                    m_urun = 0;
                end else begin
                    cur    = '{pix: '0, rv: 1'b0, bl: 1'b1};
                    m_urun = 1;
                end
            end else begin
                m_urun = 0;
            end
            m_video = cur.bl ? 1'b0 : (cur.pix[DOTS-1-phase] ^ cur.rv);
            m_hs    = hs;
            m_vs    = vs;
            phase   = (phase + 1) % DOTS;
        end else begin
            m_urun = 0;
        end
        if (m_acc) q.push_back('{pix: pix, rv: rv, bl: bl});
        @(posedge clk);
        #1;
        chk("video", video_o, m_video);
        chk("h_sync", h_sync_o, m_hs);
        chk("v_sync", v_sync_o, m_vs);
        chk("underrun", underrun_o, m_urun);
        if (en) seen = {seen[6:0], video_o};
    endtask

    // n dot periods with a strobe every second clock and no new cells.
    task automatic idle_dots(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 8'h00, 0, 0, 0, 0);
            cyc(0, 0, 8'h00, 0, 0, 0, 0);
        end
    endtask

    initial begin
        bit need_c2;
        reset_i = 1'b1; dot_en_i = 0; cell_valid_i = 0; pixels_i = '0;
        reverse_i = 0; blank_i = 0; h_sync_i = 0; v_sync_i = 0;
        seen = '0;
        model_reset();
        #1;
        chk("rst video", video_o, 1'b0);
        chk("rst h_sync", h_sync_o, 1'b0);
        chk("rst v_sync", v_sync_o, 1'b0);
        chk("rst underrun", underrun_o, 1'b0);
        chk("rst ready", cell_ready_o, 1'b1);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;

        // Plain cell, then an empty cell period.
        cyc(0, 1, 8'hA5, 0, 0, 0, 0);
        idle_dots(8);
        chk8("A5 stream", seen, 8'hA5);
        idle_dots(8);
        chk8("underrun stream", seen, 8'h00);

        // Reverse, then reverse with blank.
        cyc(0, 1, 8'hA5, 1, 0, 0, 0);
        idle_dots(8);
        chk8("A5 reverse", seen, 8'h5A);
        cyc(0, 1, 8'hA5, 1, 1, 0, 0);
        idle_dots(8);
        chk8("A5 blank", seen, 8'h00);

        // Fill without dots, then drain three cells back to back.
        cyc(0, 1, 8'h3C, 0, 0, 0, 0);
        cyc(0, 1, 8'hC3, 0, 0, 0, 0);
        cyc(0, 1, 8'h81, 0, 0, 0, 0);
        chk("full ready", cell_ready_o, 1'b0);
        need_c2 = 1;
        for (int i = 0; i < 24; i++) begin
            cyc(1, need_c2, 8'h81, 0, 0, 0, 0);
            if (m_acc) need_c2 = 0;
            cyc(0, need_c2, 8'h81, 0, 0, 0, 0);
            if (m_acc) need_c2 = 0;
            if (i == 7)  chk8("cell0", seen, 8'h3C);
            if (i == 15) chk8("cell1", seen, 8'hC3);
        end
        chk8("cell2", seen, 8'h81);

        // Push coincident with a load on an empty FIFO.
        cyc(1, 1, 8'hFF, 0, 0, 0, 0);
        chk("coincident underrun", underrun_o, 1'b1);
        cyc(0, 0, 8'h00, 0, 0, 0, 0);
        idle_dots(7);
        chk8("coincident blank", seen, 8'h00);
        idle_dots(8);
        chk8("coincident next", seen, 8'hFF);

        // Sync retiming: change one clk after a dot edge, see it on the next one.
        cyc(1, 0, 8'h00, 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 1, 0);
        cyc(1, 0, 8'h00, 0, 0, 1, 0);
        chk("h_sync rise", h_sync_o, 1'b1);
        cyc(0, 0, 8'h00, 0, 0, 0, 1);
        cyc(1, 0, 8'h00, 0, 0, 0, 1);
        chk("v_sync rise", v_sync_o, 1'b1);
        cyc(0, 0, 8'h00, 0, 0, 0, 0);
        idle_dots(5);

        // Asynchronous reset at dot 3 with two cells queued.
        cyc(0, 1, 8'hFF, 0, 0, 1, 1);
        cyc(1, 1, 8'hFF, 0, 0, 1, 1);
        cyc(0, 1, 8'hFF, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 8'h00, 0, 0, 1, 1);
            cyc(0, 0, 8'h00, 0, 0, 1, 1);
        end
        chk("pre-reset video", video_o, 1'b1);
        @(negedge clk);
        #2 reset_i = 1'b1;
        #1;
        model_reset();
        chk("async video", video_o, 1'b0);
        chk("async h_sync", h_sync_o, 1'b0);
        chk("async v_sync", v_sync_o, 1'b0);
        chk("async underrun", underrun_o, 1'b0);
        chk("async ready", cell_ready_o, 1'b1);
        @(negedge clk);
        reset_i = 1'b0;
        cyc(1, 0, 8'h00, 0, 0, 0, 0);
        chk("post-reset underrun", underrun_o, 1'b1);
        cyc(0, 0, 8'h00, 0, 0, 0, 0);
        idle_dots(7);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom % 3) == 0, ($urandom % 4) != 0, 8'($urandom),
                ($urandom % 4) == 0, ($urandom % 6) == 0,
                ($urandom % 5) == 0, ($urandom % 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
